button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/debounce_pkg.sv | 15 +
 rtl/button_debouncer_if.sv | 35 +++
 rtl/debounce_channel.sv | 115 +++++++++++
 rtl/button_debouncer.sv | 49 ++++
 tb/tb_button_debouncer.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// Shared types and default parameters for the two-channel button debouncer.
package debounce_pkg;

   // Per-channel debounce FSM state: two idle levels and two checking states.
   typedef enum logic [1:0] {
      IDLE_LOW   = 2'b00,
      CHECK_HIGH = 2'b01,
      IDLE_HIGH  = 2'b10,
      CHECK_LOW  = 2'b11
   } state_t;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
   localparam int DEFAULT_SYNC_STAGES     = 2;

endpackage

// File: rtl/button_debouncer_if.sv
// Signal bundle between the debouncer and its user: raw switches in, debounced levels out.
// Optional fall pulses appear when DEBOUNCE_FALL_PULSE_EN is defined.
interface button_debouncer_if;

   logic a_raw;
   logic b_raw;
   logic a;
   logic b;
   logic a_rise;
   logic b_rise;
`ifdef DEBOUNCE_FALL_PULSE_EN
   logic a_fall;
   logic b_fall;
`endif
   logic stable;

   modport master (
      output a_raw, b_raw,
      input  a, b, a_rise, b_rise,
`ifdef DEBOUNCE_FALL_PULSE_EN
      input  a_fall, b_fall,
`endif
      input  stable
   );

   modport slave (
      input  a_raw, b_raw,
      output a, b, a_rise, b_rise,
`ifdef DEBOUNCE_FALL_PULSE_EN
      output a_fall, b_fall,
`endif
      output stable
   );

endinterface

// File: rtl/debounce_channel.sv
// One debounce channel: synchronizer chain, level FSM with check counter, edge pulses.
// The fall pulse output exists only when DEBOUNCE_FALL_PULSE_EN is defined.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
`ifdef DEBOUNCE_FALL_PULSE_EN
   output logic fall,
`endif
   output logic idle
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] COUNT_MAX = CW'(DEBOUNCE_CYCLES);

   logic [SYNC_STAGES-1:0] sync;
   logic                   synced;
   state_t                 state, state_nxt;
   logic [CW-1:0]          count, count_nxt;
   logic                   level_nxt, rise_nxt, fall_nxt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= '0;
      else     sync <= {sync[SYNC_STAGES-2:0], raw};
   end

   assign synced = sync[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE_LOW;
         count <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         level <= level_nxt;
         rise  <= rise_nxt;
      end
   end

   // A check commits once the count has reached the limit, so a one-cycle
   // synced pulse still propagates when DEBOUNCE_CYCLES is 1.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_nxt = state;
      count_nxt = count;
      level_nxt = level;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      unique case (state)
         IDLE_LOW: begin
            if (synced) begin
               state_nxt = CHECK_HIGH;
               count_nxt = CW'(1);
            end
         end
         CHECK_HIGH: begin
            if (count >= COUNT_MAX) begin
               state_nxt = IDLE_HIGH;
               count_nxt = '0;
               level_nxt = 1'b1;
               rise_nxt  = 1'b1;
            end else if (!synced) begin
               state_nxt = IDLE_LOW;
               count_nxt = '0;
            end else begin
               count_nxt = count + CW'(1);
            end
         end
         IDLE_HIGH: begin
            if (!synced) begin
               state_nxt = CHECK_LOW;
               count_nxt = CW'(1);
            end
         end
         CHECK_LOW: begin
            if (count >= COUNT_MAX) begin
               state_nxt = IDLE_LOW;
               count_nxt = '0;
               level_nxt = 1'b0;
               fall_nxt  = 1'b1;
            end else if (synced) begin
               state_nxt = IDLE_HIGH;
               count_nxt = '0;
            end else begin
               count_nxt = count + CW'(1);
            end
         end
         default: state_nxt = IDLE_LOW;
      endcase
   end

`ifdef DEBOUNCE_FALL_PULSE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) fall <= 1'b0;
      else     fall <= fall_nxt;
   end
`else
   logic fall_unused;
   assign fall_unused = fall_nxt;
`endif

   assign idle = (state == IDLE_LOW) || (state == IDLE_HIGH);

endmodule

// File: rtl/button_debouncer.sv
// Two independent switch debouncers sharing one clock; STABLE when neither is checking.
// Define DEBOUNCE_FALL_PULSE_EN to add the A_FALL/B_FALL pulse outputs.
module button_debouncer
   import debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
   input  logic               clk,
   input  logic               rst,
   button_debouncer_if.slave  bus
);

   logic idle_a;
   logic idle_b;

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
   ) u_chan_a (
      .clk   (clk),
      .rst   (rst),
      .raw   (bus.a_raw),
      .level (bus.a),
      .rise  (bus.a_rise),
`ifdef DEBOUNCE_FALL_PULSE_EN
      .fall  (bus.a_fall),
`endif
      .idle  (idle_a)
   );

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
   ) u_chan_b (
      .clk   (clk),
      .rst   (rst),
      .raw   (bus.b_raw),
      .level (bus.b),
      .rise  (bus.b_rise),
`ifdef DEBOUNCE_FALL_PULSE_EN
      .fall  (bus.b_fall),
`endif
      .idle  (idle_b)
   );

   assign bus.stable = idle_a & idle_b;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Fall pulse checks are included when DEBOUNCE_FALL_PULSE_EN is defined.
module tb_button_debouncer;
   import debounce_pkg::*;

   localparam int N_DEB  = 4;
   localparam int N_SYNC = 2;
   localparam int LAT    = N_SYNC + N_DEB;  // edges from capture to output change

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   button_debouncer_if bif ();

   button_debouncer #(
      .DEBOUNCE_CYCLES (N_DEB),
      .SYNC_STAGES     (N_SYNC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance past the next rising edge; outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      bif.a_raw = 1'b0;
      bif.b_raw = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      bif.a_raw = 1'b0;
      bif.b_raw = 1'b0;
      #1;
      // Reset state
      check("rst_a", 32'(bif.a), 0);
      check("rst_b", 32'(bif.b), 0);
      check("rst_a_rise", 32'(bif.a_rise), 0);
      check("rst_b_rise", 32'(bif.b_rise), 0);
      check("rst_stable", 32'(bif.stable), 1);
      check("rst_state_a", 32'(dut.u_chan_a.state), 32'(IDLE_LOW));
      apply_reset();

      // Scenario 1: sustained A rise; tick k passes edge k-1, output at edge LAT
      bif.a_raw = 1'b1;
      for (int k = 1; k <= LAT + 3; k++) begin
         tick();
         check($sformatf("s1_a_k%0d", k), 32'(bif.a), 32'(k >= LAT + 1));
         check($sformatf("s1_rise_k%0d", k), 32'(bif.a_rise), 32'(k == LAT + 1));
         check($sformatf("s1_stable_k%0d", k), 32'(bif.stable), 32'(!(k >= 3 && k <= LAT)));
         check($sformatf("s1_b_k%0d", k), 32'(bif.b), 0);
      end

      // Scenario 2: 3-cycle glitch never reaches the output
      apply_reset();
      bif.a_raw = 1'b1;
      tick(); tick(); tick();
      bif.a_raw = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("s2_a_k%0d", k), 32'(bif.a), 0);
         check($sformatf("s2_rise_k%0d", k), 32'(bif.a_rise), 0);
      end
      check("s2_state", 32'(dut.u_chan_a.state), 32'(IDLE_LOW));
      check("s2_count", 32'(dut.u_chan_a.count), 0);
      check("s2_stable", 32'(bif.stable), 1);

      // Scenario 3: simultaneous rise on both channels
      apply_reset();
      bif.a_raw = 1'b1;
      bif.b_raw = 1'b1;
      for (int k = 1; k <= LAT + 2; k++) begin
         tick();
         check($sformatf("s3_a_k%0d", k), 32'(bif.a), 32'(k >= LAT + 1));
         check($sformatf("s3_b_k%0d", k), 32'(bif.b), 32'(k >= LAT + 1));
         check($sformatf("s3_arise_k%0d", k), 32'(bif.a_rise), 32'(k == LAT + 1));
         check($sformatf("s3_brise_k%0d", k), 32'(bif.b_rise), 32'(k == LAT + 1));
      end

      // Scenario 4: reset mid-check on B, then a clean rise afterwards
      apply_reset();
      bif.b_raw = 1'b1;
      tick(); tick(); tick(); tick();
      check("s4_count_pre", 32'(dut.u_chan_b.count), 2);
      check("s4_state_pre", 32'(dut.u_chan_b.state), 32'(CHECK_HIGH));
      check("s4_stable_pre", 32'(bif.stable), 0);
      rst = 1'b1;
      #1;
      check("s4_b_rst", 32'(bif.b), 0);
      check("s4_count_rst", 32'(dut.u_chan_b.count), 0);
      check("s4_state_rst", 32'(dut.u_chan_b.state), 32'(IDLE_LOW));
      check("s4_stable_rst", 32'(bif.stable), 1);
      tick(); tick();
      rst = 1'b0;
      for (int k = 1; k <= LAT + 2; k++) begin
         tick();
         check($sformatf("s4_b_k%0d", k), 32'(bif.b), 32'(k >= LAT + 1));
         check($sformatf("s4_rise_k%0d", k), 32'(bif.b_rise), 32'(k == LAT + 1));
      end

      // Scenario 5: A settled high, then sustained fall
      apply_reset();
      bif.a_raw = 1'b1;
      for (int k = 1; k <= LAT + 4; k++) tick();
      check("s5_a_high", 32'(bif.a), 1);
      bif.a_raw = 1'b0;
      for (int k = 1; k <= LAT + 2; k++) begin
         tick();
         check($sformatf("s5_a_k%0d", k), 32'(bif.a), 32'(k < LAT + 1));
         check($sformatf("s5_rise_k%0d", k), 32'(bif.a_rise), 0);
`ifdef DEBOUNCE_FALL_PULSE_EN
         check($sformatf("s5_fall_k%0d", k), 32'(bif.a_fall), 32'(k == LAT + 1));
         check($sformatf("s5_bfall_k%0d", k), 32'(bif.b_fall), 0);
`endif
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
